fwd_source_pipe: RTL and testbench
==================================

FWD_SOURCE_PIPE -- requirements
Module: fwd_source_pipe

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 de_valid  in  1  decode stage holds a valid instruction.
REQ-004 de_wen  in  1  decoded instruction writes the register file.
REQ-005 de_dest  in  5  decoded destination register number.
REQ-006 de_memread  in  1  decoded instruction is a load.
REQ-007 stall  in  1  load-use stall request from the hazard logic.
REQ-008 flush  in  1  branch/exception flush; kills the instruction entering EXE.
REQ-009 exe_alu_result  in  32  ALU result of the instruction currently in EXE.
REQ-010 mem_load_data  in  32  data memory read data for the load currently in MEM.
REQ-011 exe_wen, exe_memread  out  1 each  EXE-stage write-enable and load flag.
REQ-012 exe_regsrc  out  5  EXE-stage destination register.
REQ-013 exe_wdata  out  32  EXE-stage forwardable value.
REQ-014 mem_wen  out  1; mem_regsrc  out  5; mem_wdata  out  32  MEM-stage write-back tag and value.
REQ-015 wb_wen  out  1; wb_dest  out  5; wb_wdata  out  32  register-file write port.
REQ-016 stall_cnt  out  32  stall-cycle counter (present only with PERF_CNT_EN).

Function
REQ-017 Three tag registers SHALL exist: EXE {wen, dest, memread}, MEM {wen, dest, memread, alu_q}, WB {wen, dest, wdata}.
REQ-018 EXE load: if stall or flush or !de_valid, EXE SHALL load a bubble (wen=0, dest=0, memread=0); else EXE SHALL load {de_wen & (de_dest!=0), de_dest, de_memread}.
REQ-019 A write to register 0 SHALL never be published: any stage with dest==0 SHALL drive its wen output 0.
REQ-020 MEM SHALL load EXE tags and exe_alu_result every cycle (no hold; the stall only bubbles EXE).
REQ-021 WB SHALL load MEM tags and mem_wdata every cycle.
REQ-022 exe_wdata SHALL equal exe_alu_result combinationally; for a load in EXE it is don't-care (consumer stalls on exe_memread).
REQ-023 mem_wdata SHALL equal mem_load_data when MEM memread=1, else MEM alu_q.
REQ-024 Latency: de_* accepted at edge N appears on exe_* in cycle N+1, mem_* in N+2, wb_* in N+3.
REQ-025 stall and flush simultaneously: bubble into EXE (single bubble, no double count beyond REQ-031).
REQ-026 Back-to-back stalls SHALL insert one bubble per stalled cycle; the decode stage is held by its own logic.
REQ-027 Outputs are purely register/mux driven; no combinational path from stall/flush to any output.

Reset
REQ-028 On rst=1 at an edge, EXE, MEM and WB SHALL all become bubbles: every wen=0, dest=0, memread=0, data=0.
REQ-029 Reset SHALL override stall, flush and de_valid in the same cycle; first accepted instruction is the one presented on the first edge with rst=0.
REQ-030 stall_cnt SHALL reset to 0.

Configuration
REQ-031 With macro FWD_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 on each edge where stall=1 and rst=0, wrapping 0xFFFFFFFF->0; without it, the port SHALL be absent and no counter logic synthesised.

Verification
REQ-032 Straight-line: de_wen=1, de_dest=5, ALU=0x1234 at cycle 0 -> exe_regsrc=5 cycle 1, mem_wdata=0x1234 cycle 2, wb_wen=1/wb_dest=5/wb_wdata=0x1234 cycle 3.
REQ-033 Load: de_memread=1, dest=8, mem_load_data=0xDEADBEEF in MEM -> mem_wdata=0xDEADBEEF, wb_wdata=0xDEADBEEF next cycle.
REQ-034 Stall: stall=1 for 2 cycles with valid decode -> exe_wen=0, exe_regsrc=0 for 2 cycles; older instruction still reaches WB on time.
REQ-035 r0: de_wen=1, de_dest=0 -> exe_wen, mem_wen, wb_wen all 0 through the pipe.
REQ-036 Reset mid-flight: three instructions in EXE/MEM/WB, rst=1 one cycle -> all wen=0, all data=0 next cycle.
REQ-037 Counter (FWD_PERF_CNT_EN): preload 0xFFFFFFFF via 2^32-1 stalls or force, one more stall -> stall_cnt=0; stall+flush together -> +1 only.

Source files
------------

// File: rtl/fwd_source_pipe_if.sv
// Bundles the decode-side inputs and EXE/MEM/WB forwarding outputs of fwd_source_pipe.
// master: the environment (decode, ALU, data memory, hazard logic); slave: the pipe.
interface fwd_source_pipe_if;
   logic        de_valid;
   logic        de_wen;
   logic [4:0]  de_dest;
   logic        de_memread;
   logic        stall;
   logic        flush;
   logic [31:0] exe_alu_result;
   logic [31:0] mem_load_data;

   logic        exe_wen;
   logic        exe_memread;
   logic [4:0]  exe_regsrc;
   logic [31:0] exe_wdata;
   logic        mem_wen;
   logic [4:0]  mem_regsrc;
   logic [31:0] mem_wdata;
   logic        wb_wen;
   logic [4:0]  wb_dest;
   logic [31:0] wb_wdata;

   modport master (
      output de_valid, de_wen, de_dest, de_memread, stall, flush, exe_alu_result,
             mem_load_data,
      input  exe_wen, exe_memread, exe_regsrc, exe_wdata, mem_wen, mem_regsrc, mem_wdata,
             wb_wen, wb_dest, wb_wdata
   );

   modport slave (
      input  de_valid, de_wen, de_dest, de_memread, stall, flush, exe_alu_result,
             mem_load_data,
      output exe_wen, exe_memread, exe_regsrc, exe_wdata, mem_wen, mem_regsrc, mem_wdata,
             wb_wen, wb_dest, wb_wdata
   );
endinterface

// File: rtl/fwd_source_pipe.sv
// EXE/MEM/WB destination-tag pipeline that publishes forwarding sources and the
// register-file write port. Optional stall-cycle counter enabled by FWD_PERF_CNT_EN.
module fwd_source_pipe (
   input  logic               clk,
   input  logic               rst,
   fwd_source_pipe_if.slave   pipe
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);

   logic        exe_wen_q, exe_wen_d;
   logic [4:0]  exe_dest_q, exe_dest_d;
   logic        exe_memread_q, exe_memread_d;

   logic        mem_wen_q;
   logic [4:0]  mem_dest_q;
   logic        mem_memread_q;
   logic [31:0] mem_alu_q;

   logic        wb_wen_q;
   logic [4:0]  wb_dest_q;
   logic [31:0] wb_wdata_q;

   logic [31:0] mem_wdata;
   logic        take;

   // EXE next state: a bubble unless a valid, unstalled, unflushed instruction enters.
   always_comb begin
      take          = pipe.de_valid & ~pipe.stall & ~pipe.flush;
      exe_wen_d     = 1'b0;
      exe_dest_d    = 5'd0;
      exe_memread_d = 1'b0;
      if (take) begin
         exe_wen_d     = pipe.de_wen & (pipe.de_dest != 5'd0);
         exe_dest_d    = pipe.de_dest;
         exe_memread_d = pipe.de_memread;
      end
   end

   // Loads in MEM forward the memory read data; everything else forwards the ALU result.
   always_comb begin
      mem_wdata = mem_memread_q ? pipe.mem_load_data : mem_alu_q;
   end

   // Tag pipeline: EXE takes decode (or a bubble), MEM and WB advance every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         exe_wen_q     <= 1'b0;
         exe_dest_q    <= 5'd0;
         exe_memread_q <= 1'b0;
         mem_wen_q     <= 1'b0;
         mem_dest_q    <= 5'd0;
         mem_memread_q <= 1'b0;
         mem_alu_q     <= 32'd0;
         wb_wen_q      <= 1'b0;
         wb_dest_q     <= 5'd0;
         wb_wdata_q    <= 32'd0;
      end else begin
         exe_wen_q     <= exe_wen_d;
         exe_dest_q    <= exe_dest_d;
         exe_memread_q <= exe_memread_d;
         mem_wen_q     <= exe_wen_q;
         mem_dest_q    <= exe_dest_q;
         mem_memread_q <= exe_memread_q;
         mem_alu_q     <= pipe.exe_alu_result;
         wb_wen_q      <= mem_wen_q;
         wb_dest_q     <= mem_dest_q;
         wb_wdata_q    <= mem_wdata;
      end
   end

   // Output drive; wen is re-qualified with dest so r0 is never published.
   always_comb begin
      pipe.exe_wen     = exe_wen_q & (exe_dest_q != 5'd0);
      pipe.exe_memread = exe_memread_q;
      pipe.exe_regsrc  = exe_dest_q;
      pipe.exe_wdata   = pipe.exe_alu_result;
      pipe.mem_wen     = mem_wen_q & (mem_dest_q != 5'd0);
      pipe.mem_regsrc  = mem_dest_q;
      pipe.mem_wdata   = mem_wdata;
      pipe.wb_wen      = wb_wen_q & (wb_dest_q != 5'd0);
      pipe.wb_dest     = wb_dest_q;
      pipe.wb_wdata    = wb_wdata_q;
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // One count per stalled edge, wrapping naturally at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pipe.stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Randomized bench for fwd_source_pipe: a per-edge history of the stimulus is turned into
// expected stage contents by latency and reset rules, checked every cycle on the falling edge.
module tb_fwd_source_pipe;
   localparam int unsigned Hist = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_source_pipe_if bus ();

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] cnt_m = 32'd0;
   fwd_source_pipe dut (.clk(clk), .rst(rst), .pipe(bus), .stall_cnt(stall_cnt));
`else
   fwd_source_pipe dut (.clk(clk), .rst(rst), .pipe(bus));
`endif

   int checks = 0;
   int errors = 0;

   // Per-edge history of what the bench drove.
   logic        h_rst [Hist];
   logic        h_ok  [Hist];
   logic        h_wen [Hist];
   logic        h_mr  [Hist];
   logic [4:0]  h_dest[Hist];
   logic [31:0] h_alu [Hist];
   logic [31:0] h_ld  [Hist];
   int n = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic rst_at(input int e);
      return (e < 0) ? 1'b1 : h_rst[e];
   endfunction

   function automatic logic [31:0] alu_at(input int e);
      return (e < 0) ? 32'd0 : h_alu[e];
   endfunction

   // Instruction accepted at edge e as {published wen, memread, dest}; zero if bubble.
   function automatic logic [6:0] tag(input int e);
      if (e < 0) return 7'd0;
      if (h_rst[e] || !h_ok[e]) return 7'd0;
      return {h_wen[e] && (h_dest[e] != 5'd0), h_mr[e], h_dest[e]};
   endfunction

   // Record stimulus at each rising edge.
   always @(posedge clk) begin
      if (n < Hist) begin
         h_rst[n]  = rst;
         h_ok[n]   = bus.de_valid && !bus.stall && !bus.flush;
         h_wen[n]  = bus.de_wen;
         h_mr[n]   = bus.de_memread;
         h_dest[n] = bus.de_dest;
         h_alu[n]  = bus.exe_alu_result;
         h_ld[n]   = bus.mem_load_data;
      end
`ifdef FWD_PERF_CNT_EN
      if (rst) cnt_m = 32'd0;
      else if (bus.stall) cnt_m = cnt_m + 32'd1;
`endif
      n++;
   end

   // Compare process: every cycle, against the history-derived expectation.
   always @(negedge clk) begin
      logic [6:0]  t, m, w;
      logic        r1, r2;
      logic [31:0] exp_d;
      if (n >= 1 && n <= Hist) begin
         r1 = rst_at(n - 1);
         r2 = rst_at(n - 2);
         t = tag(n - 1);
         chk("exe_wen", {31'd0, bus.exe_wen}, {31'd0, t[6]});
         chk("exe_memread", {31'd0, bus.exe_memread}, {31'd0, t[5]});
         chk("exe_regsrc", {27'd0, bus.exe_regsrc}, {27'd0, t[4:0]});
         if (!t[5]) chk("exe_wdata", bus.exe_wdata, bus.exe_alu_result);
         m = r1 ? 7'd0 : tag(n - 2);
         chk("mem_wen", {31'd0, bus.mem_wen}, {31'd0, m[6]});
         chk("mem_regsrc", {27'd0, bus.mem_regsrc}, {27'd0, m[4:0]});
         exp_d = r1 ? 32'd0 : (m[5] ? bus.mem_load_data : alu_at(n - 1));
         chk("mem_wdata", bus.mem_wdata, exp_d);
         w = (r1 || r2) ? 7'd0 : tag(n - 3);
         chk("wb_wen", {31'd0, bus.wb_wen}, {31'd0, w[6]});
         chk("wb_dest", {27'd0, bus.wb_dest}, {27'd0, w[4:0]});
         exp_d = (r1 || r2) ? 32'd0 : (w[5] ? h_ld[n - 1] : alu_at(n - 2));
         chk("wb_wdata", bus.wb_wdata, exp_d);
`ifdef FWD_PERF_CNT_EN
         chk("stall_cnt", stall_cnt, cnt_m);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic de(input logic v, input logic wen, input logic [4:0] d, input logic mr);
      bus.de_valid   = v;
      bus.de_wen     = wen;
      bus.de_dest    = d;
      bus.de_memread = mr;
   endtask

   initial begin
      de(1'b1, 1'b1, 5'd7, 1'b0);
      bus.stall          = 1'b1;
      bus.flush          = 1'b0;
      bus.exe_alu_result = 32'h5555_AAAA;
      bus.mem_load_data  = 32'h1111_2222;
      rst = 1'b1;
      step();
      step();
      chk("reset_exe_wen", {31'd0, bus.exe_wen}, 32'd0);
      chk("reset_wb_wdata", bus.wb_wdata, 32'd0);
      chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      bus.stall = 1'b0;

      // Straight-line ALU instruction to r5.
      de(1'b1, 1'b1, 5'd5, 1'b0);
      step();
      de(1'b0, 1'b0, 5'd0, 1'b0);
      chk("line_exe_regsrc", {27'd0, bus.exe_regsrc}, 32'd5);
      chk("line_exe_wen", {31'd0, bus.exe_wen}, 32'd1);
      bus.exe_alu_result = 32'h0000_1234;
      step();
      bus.exe_alu_result = 32'h9999_0000;
      chk("line_mem_wdata", bus.mem_wdata, 32'h0000_1234);
      step();
      chk("line_wb_wen", {31'd0, bus.wb_wen}, 32'd1);
      chk("line_wb_dest", {27'd0, bus.wb_dest}, 32'd5);
      chk("line_wb_wdata", bus.wb_wdata, 32'h0000_1234);

      // Load to r8.
      de(1'b1, 1'b1, 5'd8, 1'b1);
      step();
      de(1'b0, 1'b0, 5'd0, 1'b0);
      chk("load_exe_memread", {31'd0, bus.exe_memread}, 32'd1);
      step();
      bus.mem_load_data = 32'hDEAD_BEEF;
      #1;
      chk("load_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      step();
      bus.mem_load_data = 32'h0BAD_F00D;
      chk("load_wb_wdata", bus.wb_wdata, 32'hDEAD_BEEF);

      // Two-cycle stall behind an older instruction to r3.
      de(1'b1, 1'b1, 5'd3, 1'b0);
      step();
      de(1'b1, 1'b1, 5'd4, 1'b0);
      bus.stall = 1'b1;
      step();
      chk("stall1_exe_wen", {31'd0, bus.exe_wen}, 32'd0);
      chk("stall1_exe_regsrc", {27'd0, bus.exe_regsrc}, 32'd0);
      chk("stall1_mem_regsrc", {27'd0, bus.mem_regsrc}, 32'd3);
      step();
      bus.stall = 1'b0;
      chk("stall2_exe_regsrc", {27'd0, bus.exe_regsrc}, 32'd0);
      chk("stall2_wb_dest", {27'd0, bus.wb_dest}, 32'd3);
      chk("stall2_wb_wen", {31'd0, bus.wb_wen}, 32'd1);
      step();
      chk("unstall_exe_regsrc", {27'd0, bus.exe_regsrc}, 32'd4);

      // Write to r0 never published.
      de(1'b1, 1'b1, 5'd0, 1'b0);
      step();
      de(1'b0, 1'b0, 5'd0, 1'b0);
      chk("r0_exe_wen", {31'd0, bus.exe_wen}, 32'd0);
      step();
      chk("r0_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
      step();
      chk("r0_wb_wen", {31'd0, bus.wb_wen}, 32'd0);

      // Reset with three instructions in flight.
      for (int i = 1; i <= 3; i++) begin
         de(1'b1, 1'b1, 5'(i), 1'b0);
         bus.exe_alu_result = 32'hA000_0000 + 32'(i);
         step();
      end
      bus.mem_load_data = 32'hFFFF_FFFF;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_exe_wen", {31'd0, bus.exe_wen}, 32'd0);
      chk("midrst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
      chk("midrst_wb_wen", {31'd0, bus.wb_wen}, 32'd0);
      chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("midrst_wb_wdata", bus.wb_wdata, 32'd0);

`ifdef FWD_PERF_CNT_EN
      // Counter wrap, and stall+flush together counting once.
      de(1'b0, 1'b0, 5'd0, 1'b0);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      cnt_m = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      step();
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      chk("cnt_wrap", stall_cnt, 32'd0);
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      step();
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      chk("cnt_stall_flush", stall_cnt, 32'd1);
`endif

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         de($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 2) == 0);
         bus.stall          = $urandom_range(0, 3) == 0;
         bus.flush          = $urandom_range(0, 6) == 0;
         bus.exe_alu_result = $urandom;
         bus.mem_load_data  = $urandom;
         rst                = $urandom_range(0, 49) == 0;
         step();
      end
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
